// File: rtl/div_share_arbiter.sv
// div_share_arbiter
//   Shares one in-order, untagged, pipelined divider among N_REQ requesters.
//   Requests are picked round-robin. A grant that stalls on divider ready is
//   locked until its handshake completes. The number of operations in flight
//   is limited by a tag FIFO that records which requester issued each
//   operation. Each divider result is routed back to the requester at the
//   FIFO head.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid_i / req_ready_o         per-requester issue handshake
//   req_dividend_i / req_divisor_i    packed operands, requester k at slice k
//   rsp_valid_o / rsp_ready_i         one-hot result valid, per-requester ready
//   rsp_quotient_o / rsp_remainder_o  shared result bus (pass-through)
//   div_valid_o / div_ready_i         issue handshake to the divider
//   div_dividend_o / div_divisor_o    operands of the granted requester
//   div_valid_i / div_ready_o         result handshake from the divider
//   div_quotient_i / div_remainder_i  divider results
//   outstanding_o                     operations in flight (tag FIFO occupancy)
//   err_o                             sticky: divider result with no tag
module div_share_arbiter #(
  parameter int N_REQ           = 4,
  parameter int DIVIDEND_WIDTH  = 8,
  parameter int DIVISOR_WIDTH   = 8,
  parameter int MAX_OUTSTANDING = 16,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  input  logic [N_REQ*DIVIDEND_WIDTH-1:0]   req_dividend_i,
  input  logic [N_REQ*DIVISOR_WIDTH-1:0]    req_divisor_i,
  output logic [N_REQ-1:0]                  rsp_valid_o,
  input  logic [N_REQ-1:0]                  rsp_ready_i,
  output logic [DIVIDEND_WIDTH-1:0]         rsp_quotient_o,
  output logic [DIVISOR_WIDTH-1:0]          rsp_remainder_o,
  output logic                              div_valid_o,
  input  logic                              div_ready_i,
  output logic [DIVIDEND_WIDTH-1:0]         div_dividend_o,
  output logic [DIVISOR_WIDTH-1:0]          div_divisor_o,
  input  logic                              div_valid_i,
  output logic                              div_ready_o,
  input  logic [DIVIDEND_WIDTH-1:0]         div_quotient_i,
  input  logic [DIVISOR_WIDTH-1:0]          div_remainder_i,
  output logic [CNT_W-1:0]                  outstanding_o,
  output logic                              err_o
);

  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [AW-1:0]    LAST_SLOT = AW'(MAX_OUTSTANDING - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  // Arbitration state
  logic [ID_W-1:0] r_ptr;
  logic            r_lock;
  logic [ID_W-1:0] r_lock_id;

  // Tag FIFO: requester ID of every in-flight operation, in issue order
  logic [ID_W-1:0] r_tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic            r_err;

  logic                      w_found;
  logic [ID_W-1:0]           w_rr_id;
  logic [ID_W:0]             w_cand;
  logic                      w_credit_ok;
  logic                      w_grant_vld;
  logic [ID_W-1:0]           w_grant_id;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_empty;
  logic [ID_W-1:0]           w_head;
  logic                      w_rsp_vld;
  logic [DIVIDEND_WIDTH-1:0] w_dvd [N_REQ];
  logic [DIVISOR_WIDTH-1:0]  w_dvs [N_REQ];

  // Round-robin search: first valid requester at or after r_ptr, with wrap.
  // The candidate index is formed one bit wider so that the wrap needs only
  // a single conditional subtract.
  always_comb begin
    w_found = 1'b0;
    w_rr_id = '0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_cand >= (ID_W+1)'(N_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(N_REQ);
      end
      if (!w_found && req_valid_i[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_rr_id = w_cand[ID_W-1:0];
      end
    end
  end

  // A stalled grant keeps its ID. The lock can only be taken while credit
  // is available, and credit cannot shrink without an issue, so the credit
  // gate never breaks a lock.
  assign w_credit_ok = (r_count < MAX_CNT);
  assign w_grant_id  = r_lock ? r_lock_id : w_rr_id;
  assign w_grant_vld = !rst_i && w_credit_ok &&
                       (r_lock ? req_valid_i[r_lock_id] : w_found);
  assign w_push      = w_grant_vld && div_ready_i;

  assign div_valid_o    = w_grant_vld;
  assign div_dividend_o = w_grant_vld ? w_dvd[w_grant_id] : '0;
  assign div_divisor_o  = w_grant_vld ? w_dvs[w_grant_id] : '0;

  // Response routing from the FIFO head. With an empty FIFO the divider is
  // always drained so a stray result cannot block it.
  assign w_empty   = (r_count == '0);
  assign w_head    = r_tag_mem[r_rd_ptr];
  assign w_rsp_vld = !rst_i && div_valid_i && !w_empty;
  assign div_ready_o = !rst_i && (w_empty || rsp_ready_i[w_head]);
  assign w_pop       = div_valid_i && div_ready_o && !w_empty;

  assign rsp_quotient_o  = div_quotient_i;
  assign rsp_remainder_o = div_remainder_i;
  assign outstanding_o   = r_count;
  assign err_o           = r_err;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_dvd[gi]       = req_dividend_i[gi*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
      assign w_dvs[gi]       = req_divisor_i[gi*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      assign req_ready_o[gi] = w_push && (w_grant_id == ID_W'(gi));
      assign rsp_valid_o[gi] = w_rsp_vld && (w_head == ID_W'(gi));
    end
  endgenerate

  // Tag storage needs no reset: only entries counted by r_count are read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant_id;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_lock   <= 1'b0;
        r_ptr    <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + 1'b1;
        r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
      end else if (w_grant_vld) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant_id;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (div_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one pipelined divider (valid/ready, fixed latency DIVIDEND_WIDTH+2 when not stalled, in-order, untagged) among N_REQ requesters.
- Round-robin arbitration with a locked grant and a credit limit on outstanding operations.
- Tracks requester IDs in an internal tag FIFO and routes each in-order result back to the requester that issued it.
- Sits between client blocks and the divider instance; divider and arbiter share clk_i/rst_i.

Parameters:
- N_REQ, 4, number of requesters (>=2); ID_W = max(1, clog2(N_REQ)), derived.
- DIVIDEND_WIDTH, 8, dividend/quotient width.
- DIVISOR_WIDTH, 8, divisor/remainder width.
- MAX_OUTSTANDING, 16, tag FIFO depth = max in-flight ops; must be >= DIVIDEND_WIDTH+2 for full throughput; any value >=1 is legal.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester request accepted.
- req_dividend_i  in  N_REQ*DIVIDEND_WIDTH  packed dividends; requester k at slice k.
- req_divisor_i  in  N_REQ*DIVISOR_WIDTH  packed divisors.
- rsp_valid_o  out  N_REQ  one-hot result valid.
- rsp_ready_i  in  N_REQ  per-requester result ready.
- rsp_quotient_o  out  DIVIDEND_WIDTH  shared quotient bus.
- rsp_remainder_o  out  DIVISOR_WIDTH  shared remainder bus.
- div_valid_o  out  1  issue valid to divider.
- div_ready_i  in  1  divider input ready.
- div_dividend_o  out  DIVIDEND_WIDTH  dividend to divider.
- div_divisor_o  out  DIVISOR_WIDTH  divisor to divider.
- div_valid_i  in  1  divider result valid.
- div_ready_o  out  1  ready to divider output.
- div_quotient_i  in  DIVIDEND_WIDTH  divider quotient.
- div_remainder_i  in  DIVISOR_WIDTH  divider remainder.
- outstanding_o  out  clog2(MAX_OUTSTANDING+1)  in-flight count (= tag FIFO occupancy).
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async): rr pointer=0, grant lock cleared, tag FIFO empty, outstanding_o=0, err_o=0. All valid/ready outputs are 0 while rst_i is high.
- Reset mid-operation discards all in-flight tags; the divider is reset by the same rst_i.
- Arbitration (unlocked):
  - Grant = first k with req_valid_i[k], searching from pointer upward with wrap.
  - Grant considered only if outstanding_o < MAX_OUTSTANDING.
- Grant lock:
  - If div_valid_o=1 and div_ready_i=0, the grant ID is registered and held until the handshake completes.
  - Requesters must hold valid and data stable until ready.
- Issue outputs:
  - div_valid_o = grant exists; data = granted slices (0 when no grant).
  - req_ready_o[g] = div_ready_i for the granted g only; other bits 0.
  - div_valid_o never depends on div_ready_i.
- Issue handshake (div_valid_o & div_ready_i):
  - Push g into the tag FIFO.
  - Pointer <= (g+1) mod N_REQ; lock cleared.
  - Pointer is unchanged when no issue occurs.
- Credit full (outstanding_o == MAX_OUTSTANDING): div_valid_o=0, all req_ready_o=0, even if div_ready_i=1.
- Response path, h = FIFO head:
  - rsp_valid_o = one-hot(h) when div_valid_i=1 and FIFO non-empty, else 0.
  - rsp_quotient_o/rsp_remainder_o = div_quotient_i/div_remainder_i, combinational pass-through.
  - div_ready_o = rsp_ready_i[h] when FIFO non-empty. div_ready_o never depends on div_ready_i (no combinational loop with the divider's ready chain).
  - Pop on div_valid_i & div_ready_o.
- Simultaneous push and pop: occupancy unchanged, ordering preserved. A pop from full plus a push in the same cycle is allowed only if the credit check passed at the start of the cycle, i.e. no issue when full.
- Protocol error: div_valid_i=1 with an empty FIFO sets err_o (sticky until reset), drives div_ready_o=1 to drain, and asserts no rsp_valid_o.
- Latency: 0-cycle combinational arbitration and response routing; end-to-end = divider latency plus back-pressure stalls.
- Width rule: results are routed unmodified; divide-by-zero results are whatever the divider produces.

Test Plan:
- Single op: req0 sends 100/7 with div_ready_i=1 -> issue in the same cycle, outstanding_o=1; divider result 14 r 2 -> rsp_valid_o=4'b0001, then outstanding_o=0.
- Fairness: all 4 requesters valid continuously, divider always ready -> issue order 0,1,2,3,0,1,... with pointer wrap; each gets exactly 1 issue per 4 cycles.
- Grant lock: req2 valid, div_ready_i=0 for 3 cycles, req0 asserts in cycle 2 -> grant stays 2 until handshake; req0 is issued next.
- Credit limit: MAX_OUTSTANDING=4, divider output stalled (all rsp_ready_i=0) -> exactly 4 issues, then div_valid_o=0. Releasing rsp_ready_i and popping one -> the next issue occurs in the following cycle.
- Routing with back-pressure: issues from req 1,3,1 with rsp_ready_i[3]=0 for 5 cycles -> the second result is held on the bus with rsp_valid_o=4'b1000 and div_ready_o=0. The third result is not delivered until the second pops; order is preserved.
- Error/reset: div_valid_i=1 with an empty FIFO -> err_o=1 sticky. Assert rst_i with 3 ops in flight -> outstanding_o=0, err_o=0, pointer=0 asynchronously.
